// File: rtl/powersyn_pkg.sv
// rtl/powersyn_pkg.sv - shared FSM state type and popcount helper for the power-synthesis harness
package powersyn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // Callers zero-extend narrower vectors to 64 bits.
   function automatic logic [6:0] popcount(input logic [63:0] v);
      logic [6:0] n;
      n = '0;
      for (int i = 0; i < 64; i++) begin
         n = n + 7'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational cyclic first-one finder starting at ptr
module rr_pick #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] idx,
   output logic           any
);

   int j;

   always_comb begin
      grant = '0;
      idx   = '0;
      j     = 0;
      any   = |req;
      // Walk offsets from farthest to nearest so the nearest set bit wins.
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (req[j]) begin
            idx = IDW'(j);
         end
      end
      if (any) begin
         grant[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/frg1_eval_sched.sv
// rtl/frg1_eval_sched.sv - round-robin scheduler sharing one frg1 core, with operand isolation and toggle count
module frg1_eval_sched
   import powersyn_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = 28,
   parameter int OW   = 3,
   parameter int CW   = 16,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*IW-1:0] req_vec,
   output logic [IW-1:0]      core_in,
   input  logic [OW-1:0]      core_out,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [OW-1:0]      rsp_data,
   output logic [IDW-1:0]     rsp_id,
   input  logic               clr_stats,
   output logic [CW-1:0]      tog_cnt
);

   localparam int SW = CW + 8;

   state_t          state, state_nxt;
   logic [IDW-1:0]  ptr;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  gidx;
   logic            any;
   logic            accept;
   logic [IW-1:0]   vec_sel;
   logic [CW-1:0]   tog_base;
   logic [SW-1:0]   tog_sum;
   logic [CW-1:0]   tog_nxt;

   rr_pick #(.N(NREQ), .IDW(IDW)) u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (gidx),
      .any   (any)
   );

   assign vec_sel = req_vec[int'(gidx)*IW +: IW];

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any && !rst) begin
               accept    = 1'b1;
               req_ready = grant;
               state_nxt = ST_EVAL;
            end
         end
         ST_EVAL: state_nxt = ST_HOLD;
         ST_HOLD: begin
            if (rsp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // A same-cycle clear drops the old count before this accept's toggles are added.
   always_comb begin
      tog_base = clr_stats ? '0 : tog_cnt;
      tog_sum  = SW'(tog_base) + SW'(popcount(64'(core_in ^ vec_sel)));
      tog_nxt  = (tog_sum > SW'({CW{1'b1}})) ? {CW{1'b1}} : tog_sum[CW-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         core_in   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
         tog_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            core_in <= vec_sel;
            rsp_id  <= gidx;
            tog_cnt <= tog_nxt;
         end else if (clr_stats) begin
            tog_cnt <= '0;
         end
         if (state == ST_EVAL) begin
            rsp_data  <= core_out;
            rsp_valid <= 1'b1;
         end
         if (state == ST_HOLD && rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_frg1_eval_sched.sv
// tb/tb_frg1_eval_sched.sv - scoreboard bench for frg1_eval_sched (CW=16 and CW=4 instances)
module tb_frg1_eval_sched;

   localparam int NREQ = 4;
   localparam int IW   = 28;
   localparam int OW   = 3;
   localparam int IDW  = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ*IW-1:0] req_vec = '0;
   logic               rsp_ready = 1'b1;
   logic               clr_stats = 1'b0;

   logic [NREQ-1:0] req_ready, req_ready4;
   logic [IW-1:0]   core_in, core_in4;
   logic [OW-1:0]   core_out, core_out4;
   logic            rsp_valid, rsp_valid4;
   logic [OW-1:0]   rsp_data, rsp_data4;
   logic [IDW-1:0]  rsp_id, rsp_id4;
   logic [15:0]     tog_cnt;
   logic [3:0]      tog4;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [2:0] core_fn(input logic [27:0] x);
      return x[2:0] ^ x[27:25] ^ {x[10], x[5], x[20]};
   endfunction

   assign core_out  = core_fn(core_in);
   assign core_out4 = core_fn(core_in4);

   frg1_eval_sched #(.NREQ(NREQ), .IW(IW), .OW(OW), .CW(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_vec(req_vec), .core_in(core_in), .core_out(core_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_id(rsp_id), .clr_stats(clr_stats), .tog_cnt(tog_cnt)
   );

   frg1_eval_sched #(.NREQ(NREQ), .IW(IW), .OW(OW), .CW(4)) dut4 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
      .req_vec(req_vec), .core_in(core_in4), .core_out(core_out4),
      .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_data(rsp_data4),
      .rsp_id(rsp_id4), .clr_stats(clr_stats), .tog_cnt(tog4)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference model of the scheduler, advanced once per cycle at the negedge.
   typedef struct {
      int         id;
      logic [2:0] data;
   } exp_t;

   exp_t        sb[$];
   int          glog_id[$];
   int          glog_cyc[$];
   int          cyc = 0;
   bit          m_init = 0;
   int          m_state = 0;
   int          m_ptr = 0;
   logic [27:0] m_core_in = '0;
   int          m_tog16 = 0;
   int          m_tog4 = 0;

   function automatic int pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   always @(negedge clk) begin : monitor
      int              g;
      int              pc;
      logic [NREQ-1:0] exp_ready;
      logic [IW-1:0]   v;
      exp_t            e;
      cyc++;
      if (!m_init) begin
         if (rst) begin
            m_init = 1;
            m_state = 0; m_ptr = 0; m_core_in = '0; m_tog16 = 0; m_tog4 = 0;
         end
      end else begin
         exp_ready = '0;
         g = -1;
         if (m_state == 0 && !rst && |req_valid) begin
            g = pick(req_valid, m_ptr);
            exp_ready[g] = 1'b1;
         end
         chk("req_ready", req_ready, exp_ready);
         chk("req_ready4", req_ready4, exp_ready);
         chk("rsp_valid", rsp_valid, (m_state == 2));
         chk("core_in", core_in, m_core_in);
         chk("tog_cnt", tog_cnt, m_tog16);
         chk("tog_cnt4", tog4, m_tog4);
         if (m_state == 2) begin
            if (sb.size() == 0) begin
               chk("sb_empty", 1, 0);
            end else begin
               chk("rsp_data", rsp_data, sb[0].data);
               chk("rsp_id", rsp_id, sb[0].id);
            end
         end
         if (rst) begin
            m_state = 0; m_ptr = 0; m_core_in = '0; m_tog16 = 0; m_tog4 = 0;
            sb.delete();
         end else begin
            if (clr_stats) begin
               m_tog16 = 0;
               m_tog4  = 0;
            end
            case (m_state)
               0: if (g >= 0) begin
                  v  = req_vec[g*IW +: IW];
                  pc = $countones(m_core_in ^ v);
                  m_tog16 = sat(m_tog16 + pc, 65535);
                  m_tog4  = sat(m_tog4 + pc, 15);
                  m_core_in = v;
                  e.id = g;
                  e.data = core_fn(v);
                  sb.push_back(e);
                  glog_id.push_back(g);
                  glog_cyc.push_back(cyc);
                  m_state = 1;
               end
               1: m_state = 2;
               default: if (rsp_ready) begin
                  if (sb.size() > 0) begin
                     e = sb.pop_front();
                     m_ptr = (e.id + 1) % NREQ;
                  end
                  m_state = 0;
               end
            endcase
         end
      end
   end

   task automatic do_rst();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic do_req(input int id, input logic [IW-1:0] v, input bit clr);
      bit got;
      req_valid[id] = 1'b1;
      req_vec[id*IW +: IW] = v;
      clr_stats = clr;
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (req_ready[id]) got = 1;
      end
      if (!got) chk("req_timeout", 0, 1);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      clr_stats = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin : stim
      int c0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // single request from requester 2
      do_req(2, 28'h00000FF, 0);
      chk("t1_tog", tog_cnt, 8);

      // four continuous requesters, round-robin from ptr 0
      do_rst();
      glog_id.delete(); glog_cyc.delete();
      for (int i = 0; i < NREQ; i++) req_vec[i*IW +: IW] = 28'h1111111 * (i + 1);
      req_valid = '1;
      repeat (13) @(posedge clk);
      #1 req_valid = '0;
      repeat (4) @(posedge clk);
      #1;
      chk("t2_count", (glog_id.size() >= 5), 1);
      if (glog_id.size() >= 5) begin
         c0 = glog_cyc[0];
         for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_id%0d", i), glog_id[i], i % NREQ);
            chk($sformatf("t2_cyc%0d", i), glog_cyc[i] - c0, 3 * i);
         end
      end

      // backpressure with other requesters waiting
      rsp_ready = 1'b0;
      do_req(1, 28'hA5A5A5A, 0);
      req_valid = 4'b1101;
      repeat (5) @(posedge clk);
      #1;
      chk("t3_hold_valid", rsp_valid, 1);
      rsp_ready = 1'b1;
      req_valid = '0;
      @(posedge clk); #1;
      chk("t3_released", rsp_valid, 0);
      repeat (2) @(posedge clk);
      #1;

      // operand isolation with a repeated vector
      do_rst();
      do_req(0, 28'hFFFFFFF, 0);
      chk("t4_tog_a", tog_cnt, 28);
      do_req(3, 28'hFFFFFFF, 0);
      chk("t4_tog_b", tog_cnt, 28);
      chk("t4_core_in", core_in, 28'hFFFFFFF);

      // saturation at CW=4 and clear together with an accept
      do_rst();
      do_req(0, 28'h00003FF, 0);
      do_req(0, 28'h0000000, 0);
      chk("t5_sat4", tog4, 15);
      chk("t5_tog16", tog_cnt, 20);
      do_req(0, 28'h0000007, 1);
      chk("t5_clr4", tog4, 3);
      chk("t5_clr16", tog_cnt, 3);

      // reset while holding a response
      rsp_ready = 1'b0;
      do_req(2, 28'h1234567, 0);
      chk("t6_in_hold", rsp_valid, 1);
      req_valid = 4'b1010;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("t6_rsp_valid", rsp_valid, 0);
      chk("t6_core_in", core_in, 0);
      chk("t6_tog", tog_cnt, 0);
      chk("t6_grant", req_ready, 4'b0010);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (4) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/frg1_eval_sched.md
# frg1_eval_sched

Round-robin evaluation scheduler that shares one instance of the `frg1` combinational benchmark core among NREQ requesters. It sits between the RL power-characterisation harness and the core. It registers and holds the core's 28-bit input bus between evaluations, which isolates operands and suppresses spurious switching. It captures the 3-bit result and returns it with the requester ID, and it keeps an input-bus toggle count as a switching-activity proxy.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 1..16.
- `IW`, 28: core input width.
- `OW`, 3: core output width.
- `CW`, 16: toggle-counter width.
- `IDW`, derived as max(1, clog2(NREQ)): ID width.

Ports:
- `clk` in 1: single clock. Everything is rising-edge.
- `rst` in 1: reset. It is synchronous and active-high.
- `req_valid` in NREQ: per-requester request.
- `req_ready` out NREQ: one-hot accept pulse.
- `req_vec` in NREQ*IW: request vectors. Requester i uses bits [i*IW +: IW].
- `core_in` out IW: registered drive to the core input bus.
- `core_out` in OW: combinational core result.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_data` out OW: captured core result.
- `rsp_id` out IDW: index of the requester that owns `rsp_data`.
- `clr_stats` in 1: synchronous clear of `tog_cnt`.
- `tog_cnt` out CW: saturating count of `core_in` bit toggles.

## Operation
The FSM has three states: IDLE, EVAL and HOLD.

IDLE:
- If any `req_valid` is high, grant g, the first set bit at or after `ptr`, searching cyclically.
- Pulse `req_ready[g]` combinationally in this cycle.
- Load `req_vec[g]` into `core_in`, store g into `rsp_id`, and go to EVAL.
- If no request is pending, stay in IDLE.

EVAL:
- Settle cycle. `core_in` is stable.
- At the cycle end, sample `core_out` into `rsp_data`, set `rsp_valid`, and go to HOLD.

HOLD:
- `rsp_valid` is high and `rsp_data`/`rsp_id` are stable.
- On `rsp_ready`, clear `rsp_valid`, set `ptr` to (g+1) mod NREQ, and go to IDLE.

General rules:
- `req_ready` is zero outside IDLE. Requests arriving in EVAL or HOLD wait.
- `core_in` changes only on an accept. Otherwise it holds its value (operand isolation).
- On accept, `tog_cnt` adds popcount(`core_in_old` XOR `req_vec[g]`) and saturates at 2^CW−1.
- If `clr_stats` and an accept occur in the same cycle, `tog_cnt` takes the popcount of this accept alone (clear first, then add).
- A requester that deasserts `req_valid` before it is granted is simply skipped. No error is raised.

Reset values:
- FSM = IDLE and `ptr` = 0.
- `core_in` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `tog_cnt` = 0, `req_ready` = 0.

## Timing
- Accept in cycle T: `rsp_valid` rises at edge T+2, so the response is visible in cycle T+2.
- With `rsp_ready` held high, `rsp_valid` is high for exactly one cycle. The next accept can happen in cycle T+3.
- Minimum period is 3 cycles per evaluation.
- The core has one full cycle between the `core_in` update (edge T+1) and sampling (edge T+2). The core path must meet one clock period.
- `ptr` wraps from NREQ−1 to 0.
- With NREQ=1, the scheduler always grants 0.
- `rst` mid-transaction (EVAL or HOLD): the operation is aborted, the result is discarded, and all registers return to their reset values on the next edge.

## Structure
- Shared package `powersyn_pkg` holds the FSM state enum (IDLE/EVAL/HOLD) and the `popcount` function.
- Sub-module `rr_pick`: a combinational cyclic first-one finder. Inputs are the request vector and `ptr`; outputs are one-hot grant, binary index and `any`. This sub-module is reused by later harness arbiters.
- `frg1` stays external and is connected at the harness top level.

## Test plan
- Single request, NREQ=4: `req_valid`=0b0100, `req_vec[2]`=28'h0000_0FF, `core_out` tied to 3'b101.
  - `req_ready`=0b0100 in cycle 0.
  - `core_in`=28'h0000_0FF from cycle 1.
  - `rsp_valid`=1, `rsp_data`=3'b101, `rsp_id`=2 in cycle 2.
  - `tog_cnt`=8.
- All four requesting continuously, `rsp_ready`=1: grants follow the order 0, 1, 2, 3, 0 at cycles 0, 3, 6, 9, 12. No requester is granted twice before the others.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid`.
  - `rsp_data`/`rsp_id` are stable and `req_ready` stays 0 throughout.
  - Raising `rsp_ready` returns the FSM to IDLE on the next edge.
- Operand isolation and toggles: accept the same vector 28'hFFF_FFFF twice.
  - `tog_cnt` goes 0 → 28 → 28.
  - `core_in` does not change between the accepts.
- Saturation and clear, CW=4: accepts that toggle 10 bits then 10 bits give `tog_cnt`=15. `clr_stats` together with a 3-toggle accept gives `tog_cnt`=3.
- Reset during HOLD with `rsp_valid`=1: the next cycle shows `rsp_valid`=0, `core_in`=0, `tog_cnt`=0, and the next grant goes to the lowest pending index from `ptr`=0.
